sdram_arbiter: RTL and testbench

Three-port Avalon-MM burst arbiter in front of the shared SDRAM controller in the system clock domain. It multiplexes the VGA scanout reader (port 0), the GPU rasteriser writer (port 1) and the host bridge (port 2) onto the single SDRAM slave. Port 0 has strict priority so that scanout always meets its deadline; ports 1 and 2 share the remaining bandwidth round-robin. Read-data beats are routed back to their issuer through an in-order tag FIFO.

---
 rtl/sdram_arb_pkg.sv | 31 +++
 rtl/sdram_arb_tag_fifo.sv | 69 ++++++
 rtl/sdram_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and constants for the three-port SDRAM arbiter:
//               FSM state encoding, port identifiers and read-return tag.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

  // Width of the burst length held in each read-return tag
  localparam int TAG_BURST_W = 4;

  // Port identifiers
  localparam logic [1:0] PORT_SCAN = 2'd0;
  localparam logic [1:0] PORT_RAST = 2'd1;
  localparam logic [1:0] PORT_HOST = 2'd2;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_CMD    = 2'd1,
    WRITE_BURST = 2'd2
  } arb_state_t;

  // One entry per outstanding read command: who issued it and how many beats
  typedef struct packed {
    logic [1:0]             id;
    logic [TAG_BURST_W-1:0] burst;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/sdram_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_tag_fifo
// Description : In-order FIFO of read-return tags. Push and pop may occur in
//               the same cycle; pushes while full and pops while empty are
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output tag_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push_en;
  logic w_pop_en;

  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  assign w_push_en = push && !full;
  assign w_pop_en  = pop && !empty;

  // Storage array, written at the write pointer on every accepted push
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= push_tag;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards every pending tag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Three-port Avalon-MM burst arbiter in front of the SDRAM
//               controller. Port 0 (scanout) has strict priority, ports 1
//               and 2 share round-robin. Read beats return to their issuer
//               through an in-order tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 32,
  parameter int BURST_W  = 4,
  parameter int MAX_PEND = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            req_read,
  input  logic [2:0]            req_write,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_writedata,
  input  logic [3*DATA_W/8-1:0] req_byteenable,
  input  logic [3*BURST_W-1:0]  req_burstcount,
  output logic [2:0]            req_waitrequest,
  output logic [DATA_W-1:0]     req_readdata,
  output logic [2:0]            req_readdatavalid,
  output logic                  m_read,
  output logic                  m_write,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic [BURST_W-1:0]    m_burstcount,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid,
  output logic                  err_orphan
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t         r_state;
  logic [1:0]         r_gnt;
  logic               r_rr;
  logic [BURST_W-1:0] r_wbeat;
  logic [BURST_W-1:0] r_rbeat;
  logic [DATA_W-1:0]  r_rdata;
  logic [2:0]         r_rdv;
  logic               r_err;

  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic [BE_W-1:0]    w_sel_be;
  logic [BURST_W-1:0] w_sel_bc;
  logic [BURST_W-1:0] w_eff_bc;
  logic               w_active;
  logic [2:0]         w_elig;
  logic               w_win_valid;
  logic [1:0]         w_win;
  logic               w_win_write;
  logic               w_full;
  logic               w_empty;
  tag_t               w_head;
  tag_t               w_push_tag;
  logic               w_push;
  logic               w_pop;

  // Mux the command fields of the currently granted port
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    w_sel_bc    = '0;
    case (r_gnt)
      PORT_SCAN: begin
        w_sel_addr  = req_addr[0*ADDR_W +: ADDR_W];
        w_sel_wdata = req_writedata[0*DATA_W +: DATA_W];
        w_sel_be    = req_byteenable[0*BE_W +: BE_W];
        w_sel_bc    = req_burstcount[0*BURST_W +: BURST_W];
      end
      PORT_RAST: begin
        w_sel_addr  = req_addr[1*ADDR_W +: ADDR_W];
        w_sel_wdata = req_writedata[1*DATA_W +: DATA_W];
        w_sel_be    = req_byteenable[1*BE_W +: BE_W];
        w_sel_bc    = req_burstcount[1*BURST_W +: BURST_W];
      end
      PORT_HOST: begin
        w_sel_addr  = req_addr[2*ADDR_W +: ADDR_W];
        w_sel_wdata = req_writedata[2*DATA_W +: DATA_W];
        w_sel_be    = req_byteenable[2*BE_W +: BE_W];
        w_sel_bc    = req_burstcount[2*BURST_W +: BURST_W];
      end
      default: ;
    endcase
  end

  // A zero burstcount is treated as a single beat
  assign w_eff_bc = (w_sel_bc == '0) ? BURST_W'(1) : w_sel_bc;
  assign w_active = (r_state != IDLE);

  // Reads are eligible only while a tag slot is free; writes always are
  for (genvar gi = 0; gi < 3; gi++) begin : g_elig
    assign w_elig[gi] = req_write[gi] | (req_read[gi] & ~w_full);
  end

  // Strict priority for scanout, round-robin between rasteriser and host
  always_comb begin
    w_win_valid = 1'b0;
    w_win       = PORT_SCAN;
    if (w_elig[0]) begin
      w_win_valid = 1'b1;
      w_win       = PORT_SCAN;
    end else if (!r_rr) begin
      if (w_elig[1]) begin
        w_win_valid = 1'b1;
        w_win       = PORT_RAST;
      end else if (w_elig[2]) begin
        w_win_valid = 1'b1;
        w_win       = PORT_HOST;
      end
    end else begin
      if (w_elig[2]) begin
        w_win_valid = 1'b1;
        w_win       = PORT_HOST;
      end else if (w_elig[1]) begin
        w_win_valid = 1'b1;
        w_win       = PORT_RAST;
      end
    end
  end

  // A port strobing both read and write is served as a write
  always_comb begin
    w_win_write = 1'b0;
    case (w_win)
      PORT_SCAN: w_win_write = req_write[0];
      PORT_RAST: w_win_write = req_write[1];
      PORT_HOST: w_win_write = req_write[2];
      default:   w_win_write = 1'b0;
    endcase
  end

  // Command FSM: arbitrate in IDLE, hold the grant through the command/burst
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_gnt   <= 2'd0;
      r_rr    <= 1'b0;
      r_wbeat <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wbeat <= '0;
          if (w_win_valid) begin
            r_gnt   <= w_win;
            r_state <= w_win_write ? WRITE_BURST : READ_CMD;
            if (w_win == PORT_RAST) begin
              r_rr <= 1'b1;
            end else if (w_win == PORT_HOST) begin
              r_rr <= 1'b0;
            end
          end
        end
        READ_CMD: begin
          if (!m_waitrequest) begin
            r_state <= IDLE;
          end
        end
        WRITE_BURST: begin
          if (!m_waitrequest) begin
            if (r_wbeat + 1'b1 == w_eff_bc) begin
              r_wbeat <= '0;
              r_state <= IDLE;
            end else begin
              r_wbeat <= r_wbeat + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_read       = (r_state == READ_CMD);
  assign m_write      = (r_state == WRITE_BURST);
  assign m_addr       = w_active ? w_sel_addr  : '0;
  assign m_writedata  = w_active ? w_sel_wdata : '0;
  assign m_byteenable = w_active ? w_sel_be    : '0;
  assign m_burstcount = w_active ? w_eff_bc    : '0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_wait
    assign req_waitrequest[gi] = (w_active && (r_gnt == 2'(gi))) ? m_waitrequest : 1'b1;
  end

  assign w_push         = m_read && !m_waitrequest;
  assign w_push_tag.id    = r_gnt;
  assign w_push_tag.burst = TAG_BURST_W'(w_eff_bc);
  assign w_pop          = m_readdatavalid && !w_empty &&
                          (r_rbeat + 1'b1 == BURST_W'(w_head.burst));

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_PEND)
  ) u_tag_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (w_push),
    .push_tag (w_push_tag),
    .pop      (w_pop),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head)
  );

  // Steer returning beats to the head tag's owner; flag beats with no owner
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rbeat <= '0;
      r_rdata <= '0;
      r_rdv   <= 3'b000;
      r_err   <= 1'b0;
    end else begin
      r_rdv <= 3'b000;
      if (m_readdatavalid) begin
        if (w_empty) begin
          r_err <= 1'b1;
        end else begin
          r_rdata <= m_readdata;
          r_rdv   <= 3'b001 << w_head.id;
          r_rbeat <= w_pop ? '0 : r_rbeat + 1'b1;
        end
      end
    end
  end

  assign req_readdata      = r_rdata;
  assign req_readdatavalid = r_rdv;
  assign err_orphan        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Randomised bench for sdram_arbiter. Three port masters and an
//               SDRAM slave are driven with $urandom; a transaction-level
//               model predicts grants, command fields and read routing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 32;
  localparam int BURST_W  = 4;
  localparam int MAX_PEND = 4;
  localparam int BE_W     = DATA_W / 8;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [2:0]            req_read = '0;
  logic [2:0]            req_write = '0;
  logic [3*ADDR_W-1:0]   req_addr = '0;
  logic [3*DATA_W-1:0]   req_writedata = '0;
  logic [3*BE_W-1:0]     req_byteenable = '0;
  logic [3*BURST_W-1:0]  req_burstcount = '0;
  logic [2:0]            req_waitrequest;
  logic [DATA_W-1:0]     req_readdata;
  logic [2:0]            req_readdatavalid;
  logic                  m_read;
  logic                  m_write;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_writedata;
  logic [BE_W-1:0]       m_byteenable;
  logic [BURST_W-1:0]    m_burstcount;
  logic                  m_waitrequest = 1'b0;
  logic [DATA_W-1:0]     m_readdata = '0;
  logic                  m_readdatavalid = 1'b0;
  logic                  err_orphan;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BURST_W  (BURST_W),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_writedata     (req_writedata),
    .req_byteenable    (req_byteenable),
    .req_burstcount    (req_burstcount),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .m_read            (m_read),
    .m_write           (m_write),
    .m_addr            (m_addr),
    .m_writedata       (m_writedata),
    .m_byteenable      (m_byteenable),
    .m_burstcount      (m_burstcount),
    .m_waitrequest     (m_waitrequest),
    .m_readdata        (m_readdata),
    .m_readdatavalid   (m_readdatavalid),
    .err_orphan        (err_orphan)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Port master state
  bit                 act [3];
  bit                 is_wr [3];
  logic [ADDR_W-1:0]  p_addr [3];
  logic [BURST_W-1:0] p_bc [3];
  logic [DATA_W-1:0]  p_wd [3];
  logic [BE_W-1:0]    p_be [3];
  int                 p_beats [3];
  int                 start_pct [3];
  int                 ret_pct;
  int                 wait_pct;

  // Reference model state
  typedef struct {
    int id;
    int left;
  } ent_t;
  ent_t        tq [$];
  bit          busy;
  int          mw;
  bit          mwr;
  int          mbeats;
  bit          mrr;
  bit          exp_v;
  int          exp_id;
  logic [DATA_W-1:0] exp_d;
  bit          exp_err;

  function automatic int eff(input logic [BURST_W-1:0] b);
    return (b == 0) ? 1 : int'(b);
  endfunction

  // Who should win an arbitration given the requests and reads outstanding
  function automatic int winner(input logic [2:0] rd, input logic [2:0] wr,
                                input int pend, input bit rr);
    bit e [3];
    int first;
    int other;
    for (int i = 0; i < 3; i++) e[i] = wr[i] || (rd[i] && (pend < MAX_PEND));
    if (e[0]) return 0;
    first = rr ? 2 : 1;
    other = rr ? 1 : 2;
    if (e[first]) return first;
    if (e[other]) return other;
    return -1;
  endfunction

  task automatic model_clear();
    tq.delete();
    busy   = 1'b0;
    mw     = 0;
    mwr    = 1'b0;
    mbeats = 0;
    mrr    = 1'b0;
    exp_v  = 1'b0;
    for (int i = 0; i < 3; i++) act[i] = 1'b0;
  endtask

  task automatic drive_ports();
    for (int i = 0; i < 3; i++) begin
      req_read[i]  = act[i] && !is_wr[i];
      req_write[i] = act[i] && is_wr[i];
      req_addr[i*ADDR_W +: ADDR_W]         = p_addr[i];
      req_writedata[i*DATA_W +: DATA_W]    = p_wd[i];
      req_byteenable[i*BE_W +: BE_W]       = p_be[i];
      req_burstcount[i*BURST_W +: BURST_W] = p_bc[i];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m_read"}, m_read, 0);
    check_eq({tag, "_m_write"}, m_write, 0);
    check_eq({tag, "_waitreq"}, req_waitrequest, 3'b111);
    check_eq({tag, "_rdv"}, req_readdatavalid, 0);
    check_eq({tag, "_err"}, err_orphan, 0);
    check_eq({tag, "_m_addr"}, m_addr, 0);
    check_eq({tag, "_m_wdata"}, m_writedata, 0);
    check_eq({tag, "_m_be"}, m_byteenable, 0);
    check_eq({tag, "_m_bc"}, m_burstcount, 0);
  endtask

  // Hold reset for n cycles; outputs are checked once reset has been sampled
  task automatic rst_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset_n         = 1'b0;
      act[0]          = 1'b0;
      act[1]          = 1'b0;
      act[2]          = 1'b0;
      drive_ports();
      m_waitrequest   = 1'($urandom_range(1));
      m_readdatavalid = 1'b0;
      #1;
      if (k > 0) check_reset_outputs("reset");
    end
    model_clear();
  endtask

  // Beats arriving with no tags outstanding must be dropped and flagged
  task automatic orphan_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset_n         = 1'b1;
      drive_ports();
      m_waitrequest   = 1'b0;
      m_readdatavalid = 1'b1;
      m_readdata      = $urandom;
      #1;
      check_eq("orphan_rdv", req_readdatavalid, 0);
      check_eq("orphan_err", err_orphan, (k > 0) ? 1 : 0);
      check_eq("orphan_idle", {m_read, m_write}, 0);
    end
    exp_err = 1'b1;
  endtask

  task automatic step();
    int w;
    bit beat_v;
    logic [DATA_W-1:0] beat_d;
    logic [2:0] exp_wq;
    ent_t e;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!act[i] && ($urandom_range(99) < start_pct[i])) begin
        act[i]     = 1'b1;
        is_wr[i]   = 1'($urandom_range(1));
        p_addr[i]  = ADDR_W'($urandom);
        p_bc[i]    = BURST_W'($urandom_range(8));
        p_wd[i]    = $urandom;
        p_be[i]    = BE_W'($urandom);
        p_beats[i] = 0;
      end
    end
    drive_ports();
    m_waitrequest = ($urandom_range(99) < wait_pct);
    beat_v = (tq.size() > 0) && ($urandom_range(99) < ret_pct);
    beat_d = $urandom;
    m_readdatavalid = beat_v;
    m_readdata      = beat_d;
    #1;

    // Registered read return from the previous cycle's beat
    check_eq("rdv", req_readdatavalid, exp_v ? (3'b001 << exp_id) : 3'b000);
    if (exp_v) check_eq("rdata", req_readdata, exp_d);
    check_eq("err_orphan", err_orphan, exp_err);

    if (busy) begin
      check_eq("m_read", m_read, !mwr);
      check_eq("m_write", m_write, mwr);
      check_eq("m_addr", m_addr, p_addr[mw]);
      check_eq("m_burstcount", m_burstcount, eff(p_bc[mw]));
      if (mwr) begin
        check_eq("m_writedata", m_writedata, p_wd[mw]);
        check_eq("m_byteenable", m_byteenable, p_be[mw]);
      end
      exp_wq = 3'b111;
      exp_wq[mw] = m_waitrequest;
      check_eq("waitreq_busy", req_waitrequest, exp_wq);
      if (!m_waitrequest) begin
        if (!mwr) begin
          tq.push_back('{id: mw, left: eff(p_bc[mw])});
          busy = 1'b0;
        end else begin
          mbeats++;
          if (mbeats == eff(p_bc[mw])) busy = 1'b0;
        end
      end
    end else begin
      check_eq("idle_cmd", {m_read, m_write}, 0);
      check_eq("waitreq_idle", req_waitrequest, 3'b111);
      w = winner(req_read, req_write, tq.size(), mrr);
      if (w >= 0) begin
        busy   = 1'b1;
        mw     = w;
        mwr    = req_write[w];
        mbeats = 0;
        if (w == 1) mrr = 1'b1;
        else if (w == 2) mrr = 1'b0;
      end
    end

    exp_v = beat_v;
    if (beat_v) begin
      e      = tq[0];
      exp_id = e.id;
      exp_d  = beat_d;
      e.left--;
      if (e.left == 0) void'(tq.pop_front());
      else tq[0] = e;
    end

    // Port masters advance on their own handshakes
    for (int i = 0; i < 3; i++) begin
      if (act[i] && !req_waitrequest[i]) begin
        if (!is_wr[i]) begin
          act[i] = 1'b0;
        end else begin
          p_beats[i]++;
          p_wd[i] = $urandom;
          if (p_beats[i] == eff(p_bc[i])) act[i] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    exp_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      p_addr[i] = '0;
      p_bc[i]   = '0;
      p_wd[i]   = '0;
      p_be[i]   = '0;
      is_wr[i]  = 1'b0;
    end
    start_pct[0] = 15;
    start_pct[1] = 40;
    start_pct[2] = 40;
    model_clear();
    rst_cycles(3);

    // Alternate slow and fast read return to fill and drain the tag FIFO
    for (int p = 0; p < 6; p++) begin
      ret_pct  = (p % 2 == 1) ? 70 : 4;
      wait_pct = (p % 3 == 0) ? 50 : 15;
      for (int c = 0; c < 400; c++) step();
    end

    // Build up outstanding reads, then reset mid-operation
    ret_pct  = 0;
    wait_pct = 10;
    for (int c = 0; c < 500 && tq.size() < 2; c++) step();
    check_eq("pend_setup", (tq.size() >= 2) ? 1 : 0, 1);
    rst_cycles(3);
    orphan_cycles(3);

    ret_pct  = 50;
    wait_pct = 25;
    for (int c = 0; c < 400; c++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
